mix_columns_seq: RTL and testbench

//  Forward AES MixColumns for the encryption datapath; the counterpart of the inverse-mix stage on decrypt.

---
 rtl/mix_columns_seq.sv | 119 +++++++++++
 tb/tb_mix_columns_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES forward MixColumns engine.
// COLS_PER_CYCLE columns mixed per busy cycle, valid/ready on both sides.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  localparam int CPC = COLS_PER_CYCLE;

  generate
    if (CPC != 1 && CPC != 2 && CPC != 4) begin : g_bad_cpc
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e       state_q;
  logic [0:127] work_q;
  logic [0:127] work_d;
  logic [0:127] out_q;
  logic         byp_q;
  logic         ovalid_q;
  logic [1:0]   col_q;
  logic [1:0]   col_d;
  logic         last;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Bypass leaves the columns untouched but keeps the same cadence.
  always_comb begin
    work_d = work_q;
    for (int j = 0; j < CPC; j++) begin
      if (!byp_q) begin
        work_d[32*(int'(col_q)+j) +: 32] =
          mix_col(work_q[32*(int'(col_q)+j) +: 32]);
      end
    end
  end

  assign col_d = col_q + 2'(CPC);
  assign last  = (int'(col_q) + CPC) == 4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      out_q    <= '0;
      byp_q    <= 1'b0;
      ovalid_q <= 1'b0;
      col_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_state;
            byp_q   <= in_bypass;
            col_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          col_q  <= col_d;
          if (last) begin
            out_q    <= work_d;
            ovalid_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            ovalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ovalid_q;
  assign out_state = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed and random checks of mix_columns_seq
// for COLS_PER_CYCLE = 1, 2 and 4 against a GF(2^8) matrix model.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               iv[3];
  logic               ib[3];
  logic               ordy[3];
  logic [0:127]       st_in[3];
  logic [2:0]         ir;
  logic [2:0]         ov;
  logic [2:0][0:127]  os;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_state  (st_in[g]),
      .in_bypass (ib[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_state (os[g])
    );
  end

  function automatic int gmul(int a, int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column; inv selects InvMixColumns.
  function automatic logic [0:127] mixc(logic [0:127] s, bit inv);
    int m[4];
    int acc;
    logic [0:127] r;
    r = s;
    if (inv) m = '{14, 11, 13, 9};
    else     m = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(int'(s[32*c+8*k +: 8]), m[(k - i + 4) % 4]);
        r[32*c+8*i +: 8] = 8'(acc);
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] ref_out(logic [0:127] s, bit byp);
    return byp ? s : mixc(s, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called one tick after a rising edge with the selected engine idle.
  task automatic run_block(input int g, input logic [0:127] st,
                           input bit byp, output int lat,
                           output logic [0:127] res);
    iv[g] = 1'b1;
    st_in[g] = st;
    ib[g] = byp;
    @(posedge clk); #1;
    iv[g] = 1'b0;
    lat = 0;
    while (!ov[g] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = os[g];
    ordy[g] = 1'b1;
    @(posedge clk); #1;
    ordy[g] = 1'b0;
    chk($sformatf("idle_after_pop%0d", g), ir[g], 1);
    chk($sformatf("ov_low_after_pop%0d", g), ov[g], 0);
  endtask

  localparam logic [0:127] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [0:127] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [0:127] V2 = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
  localparam logic [0:127] R2 = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
  localparam int NBLK = 334;

  initial begin
    int lat;
    logic [0:127] res;
    logic [0:127] snap;
    int sent[3];
    int recv[3];
    int wr[3];
    int rd[3];
    logic [0:127] fs[3][4];
    bit fb[3][4];
    bit hold[3];
    logic [0:127] prev_os[3];
    int cycles;

    for (int g = 0; g < 3; g++) begin
      iv[g] = 1'b0;
      ib[g] = 1'b0;
      ordy[g] = 1'b0;
      st_in[g] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_ov%0d", g), ov[g], 0);
      chk($sformatf("reset_os%0d", g), os[g], 0);
      chk($sformatf("reset_ir%0d", g), ir[g], 1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_block(0, V1, 1'b0, lat, res);
    chk("v1_cpc1_data", res, R1);
    chk("v1_cpc1_model", res, ref_out(V1, 1'b0));
    chk("v1_cpc1_lat", lat, 4);

    run_block(2, V2, 1'b0, lat, res);
    chk("v2_cpc4_data", res, R2);
    chk("v2_cpc4_lat", lat, 1);

    run_block(1, V2, 1'b0, lat, res);
    chk("v2_cpc2_data", res, R2);
    chk("v2_cpc2_lat", lat, 2);

    iv[1] = 1'b1;
    st_in[1] = V1;
    ib[1] = 1'b0;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    lat = 0;
    while (!ov[1] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", lat, 2);
    snap = os[1];
    chk("bp_data", snap, R1);
    for (int i = 0; i < 10; i++) begin
      iv[1] = 1'b1;
      st_in[1] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_os_stable", os[1], snap);
      chk("bp_ov_held", ov[1], 1);
      chk("bp_ir_low", ir[1], 0);
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    chk("bp_release_ir", ir[1], 1);
    chk("bp_release_ov", ov[1], 0);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_no_ghost", ov[1], 0);

    run_block(0, V1, 1'b1, lat, res);
    chk("byp_cpc1_data", res, V1);
    chk("byp_cpc1_lat", lat, 4);
    run_block(2, V1, 1'b1, lat, res);
    chk("byp_cpc4_data", res, V1);
    chk("byp_cpc4_lat", lat, 1);

    iv[0] = 1'b1;
    st_in[0] = V2;
    ib[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ov", ov[0], 0);
    chk("rst_mid_os", os[0], 0);
    chk("rst_mid_ir", ir[0], 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_emit", ov[0], 0);
    run_block(0, V2, 1'b0, lat, res);
    chk("post_rst_data", res, R2);
    chk("post_rst_lat", lat, 4);

    for (int g = 0; g < 3; g++) begin
      sent[g] = 0;
      recv[g] = 0;
      wr[g] = 0;
      rd[g] = 0;
      hold[g] = 1'b0;
      prev_os[g] = '0;
    end
    cycles = 0;
    while ((recv[0] < NBLK || recv[1] < NBLK || recv[2] < NBLK)
           && cycles < 30000) begin
      for (int g = 0; g < 3; g++) begin
        if (hold[g]) begin
          chk($sformatf("rnd_ov_hold%0d", g), ov[g], 1);
          chk($sformatf("rnd_os_hold%0d", g), os[g], prev_os[g]);
        end
        chk($sformatf("rnd_ir%0d", g), ir[g], (wr[g] == rd[g]) ? 1 : 0);
        iv[g] = (sent[g] < NBLK) && ($urandom_range(0, 1) == 1);
        st_in[g] = {$urandom, $urandom, $urandom, $urandom};
        ib[g] = ($urandom_range(0, 7) == 0);
        ordy[g] = ($urandom_range(0, 2) != 0);
        if (iv[g] && ir[g]) begin
          fs[g][wr[g] % 4] = st_in[g];
          fb[g][wr[g] % 4] = ib[g];
          wr[g]++;
          sent[g]++;
        end
        if (ov[g] && ordy[g]) begin
          chk($sformatf("rnd_no_dup%0d", g), (wr[g] > rd[g]) ? 1 : 0, 1);
          if (wr[g] > rd[g]) begin
            chk($sformatf("rnd_data%0d", g), os[g],
                ref_out(fs[g][rd[g] % 4], fb[g][rd[g] % 4]));
            if (!fb[g][rd[g] % 4])
              chk($sformatf("rnd_roundtrip%0d", g), mixc(os[g], 1'b1),
                  fs[g][rd[g] % 4]);
            rd[g]++;
          end
          recv[g]++;
          hold[g] = 1'b0;
        end else begin
          hold[g] = ov[g];
        end
        prev_os[g] = os[g];
      end
      @(posedge clk); #1;
      cycles++;
    end
    for (int g = 0; g < 3; g++) begin
      iv[g] = 1'b0;
      ordy[g] = 1'b0;
      chk($sformatf("rnd_recv%0d", g), recv[g], NBLK);
      chk($sformatf("rnd_sent%0d", g), sent[g], NBLK);
      chk($sformatf("rnd_drain%0d", g), wr[g] - rd[g], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
